// File: rtl/ip_rx_process_if.sv
// rtl/ip_rx_process_if.sv - handshake and stream bundle for the IPv4 receive parser
// master drives frames in and sinks results; slave is the parser side.
interface ip_rx_process_if #(
   parameter int DROP_CNT_W = 16
);
   logic                  wMac_hdr_in_valid;
   logic                  wMac_hdr_in_ready;
   logic [15:0]           bMac_hdr_in_FrameType;
   logic                  wData_in_valid;
   logic                  wData_in_ready;
   logic [127:0]          bData_in_data;
   logic [15:0]           bData_in_keep;
   logic                  wData_in_last;
   logic                  wIp_hdr_out_valid;
   logic                  bIp_hdr_out_ready;
   logic [31:0]           bIp_hdr_out_SrcIp;
   logic [31:0]           bIp_hdr_out_DstIp;
   logic [7:0]            bIp_hdr_out_Protocol;
   logic [15:0]           bIp_hdr_out_TotalLen;
   logic                  wData_out_valid;
   logic                  wData_out_ready;
   logic [127:0]          bData_out_data;
   logic [15:0]           bData_out_keep;
   logic                  wData_out_last;
   logic [DROP_CNT_W-1:0] bDrop_cnt;

   modport slave (
      input  wMac_hdr_in_valid, bMac_hdr_in_FrameType,
      output wMac_hdr_in_ready,
      input  wData_in_valid, bData_in_data, bData_in_keep, wData_in_last,
      output wData_in_ready,
      output wIp_hdr_out_valid, bIp_hdr_out_SrcIp, bIp_hdr_out_DstIp,
      output bIp_hdr_out_Protocol, bIp_hdr_out_TotalLen,
      input  bIp_hdr_out_ready,
      output wData_out_valid, bData_out_data, bData_out_keep, wData_out_last,
      input  wData_out_ready,
      output bDrop_cnt
   );

   modport master (
      output wMac_hdr_in_valid, bMac_hdr_in_FrameType,
      input  wMac_hdr_in_ready,
      output wData_in_valid, bData_in_data, bData_in_keep, wData_in_last,
      input  wData_in_ready,
      input  wIp_hdr_out_valid, bIp_hdr_out_SrcIp, bIp_hdr_out_DstIp,
      input  bIp_hdr_out_Protocol, bIp_hdr_out_TotalLen,
      output bIp_hdr_out_ready,
      input  wData_out_valid, bData_out_data, bData_out_keep, wData_out_last,
      output wData_out_ready,
      input  bDrop_cnt
   );
endinterface

// File: rtl/ip_rx_process.sv
// rtl/ip_rx_process.sv - IPv4 receive header parser with payload realignment
// Validates the 20-byte header, then re-emits the payload from lane 0 trimmed to TotalLen.
module ip_rx_process #(
   parameter int DROP_CNT_W = 16
) (
   input  logic           wClk,
   input  logic           wRst_n,
   ip_rx_process_if.slave bus
);
   typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, FLUSH, DROP} state_t;

   state_t                state;
   logic                  rstDone;
   logic [15:0]           totalLen;
   logic [7:0]            protocol;
   logic [31:0]           srcIp;
   logic [18:0]           csumPart;
   logic [95:0]           residue;
   logic [4:0]            resCnt;
   logic [15:0]           remaining;
   logic                  hdrValid;
   logic [31:0]           hdrSrcIp, hdrDstIp;
   logic [7:0]            hdrProto;
   logic [15:0]           hdrTotalLen;
   logic                  outValid, outLast;
   logic [127:0]          outData;
   logic [15:0]           outKeep;
   logic [DROP_CNT_W-1:0] dropCnt, dropNext;

   function automatic logic [4:0] keepCount(input logic [15:0] k);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'b0, k[i]};
      return n;
   endfunction

   function automatic logic [15:0] cntMask(input logic [4:0] n);
      logic [15:0] m;
      for (int i = 0; i < 16; i++) m[i] = (5'(i) < n);
      return m;
   endfunction

   // Lane pairs arrive little-endian; header words are big-endian.
   function automatic logic [15:0] beWord(input logic [15:0] w);
      return {w[7:0], w[15:8]};
   endfunction

   logic [127:0] inData;
   logic [15:0]  inKeep;
   logic         inLast, outFree, dataInReady, beatAcc;
   logic [15:0]  inTotalLen;
   logic [18:0]  hdrSum;
   logic [19:0]  fullSum;
   logic [16:0]  fold1;
   logic [15:0]  fold2;
   logic         csumOk, hdr0Err;
   logic [4:0]   inCnt, take, avail, newRes, emit, hdr1Res, flushCnt;
   logic [15:0]  remAfter;

   assign inData  = bus.bData_in_data;
   assign inKeep  = bus.bData_in_keep;
   assign inLast  = bus.wData_in_last;
   assign outFree = !outValid || bus.wData_out_ready;
   assign beatAcc = bus.wData_in_valid && dataInReady;

   always_comb begin
      dataInReady = 1'b0;
      case (state)
         HDR0, DROP: dataInReady = 1'b1;
         HDR1:       dataInReady = outFree && !hdrValid;
         PAYLOAD:    dataInReady = outFree;
         default:    dataInReady = 1'b0;
      endcase
   end

   always_comb begin
      hdrSum = '0;
      for (int k = 0; k < 8; k++) hdrSum = hdrSum + {3'b0, beWord(inData[16*k +: 16])};
   end

   assign inTotalLen = beWord(inData[31:16]);
   assign hdr0Err    = (inData[7:0] != 8'h45) || (inTotalLen < 16'd20);
   assign fullSum    = {1'b0, csumPart} + {4'b0, beWord(inData[15:0])} + {4'b0, beWord(inData[31:16])};
   assign fold1      = {1'b0, fullSum[15:0]} + {13'b0, fullSum[19:16]};
   assign fold2      = fold1[15:0] + {15'b0, fold1[16]};
   assign csumOk     = (fold2 == 16'hFFFF);

   // Each payload beat pairs 12 residue bytes with the first 4 bytes of the new beat.
   assign inCnt    = keepCount(inKeep);
   assign take     = (inCnt > 5'd4) ? 5'd4 : inCnt;
   assign avail    = resCnt + take;
   assign newRes   = inCnt - take;
   assign emit     = ({11'b0, avail} < remaining) ? avail : remaining[4:0];
   assign remAfter = remaining - {11'b0, emit};
   assign hdr1Res  = inCnt - 5'd4;
   assign flushCnt = ({11'b0, resCnt} < remaining) ? resCnt : remaining[4:0];
   assign dropNext = (&dropCnt) ? dropCnt : dropCnt + DROP_CNT_W'(1);

   always_ff @(posedge wClk or negedge wRst_n) begin
      if (!wRst_n) begin
         state       <= IDLE;
         rstDone     <= 1'b0;
         totalLen    <= '0;
         protocol    <= '0;
         srcIp       <= '0;
         csumPart    <= '0;
         residue     <= '0;
         resCnt      <= '0;
         remaining   <= '0;
         hdrValid    <= 1'b0;
         hdrSrcIp    <= '0;
         hdrDstIp    <= '0;
         hdrProto    <= '0;
         hdrTotalLen <= '0;
         outValid    <= 1'b0;
         outLast     <= 1'b0;
         outData     <= '0;
         outKeep     <= '0;
         dropCnt     <= '0;
      end else begin
         rstDone <= 1'b1;
         if (bus.wData_out_ready)   outValid <= 1'b0;
         if (bus.bIp_hdr_out_ready) hdrValid <= 1'b0;
         case (state)
            IDLE: if (bus.wMac_hdr_in_valid && rstDone) begin
               if (bus.bMac_hdr_in_FrameType == 16'h0800) begin
                  state <= HDR0;
               end else begin
                  state   <= DROP;
                  dropCnt <= dropNext;
               end
            end
            HDR0: if (beatAcc) begin
               totalLen <= inTotalLen;
               protocol <= inData[79:72];
               srcIp    <= {inData[103:96], inData[111:104], inData[119:112], inData[127:120]};
               csumPart <= hdrSum;
               if (inLast || hdr0Err) begin
                  dropCnt <= dropNext;
                  state   <= inLast ? IDLE : DROP;
               end else begin
                  state <= HDR1;
               end
            end
            HDR1: if (beatAcc) begin
               if (!csumOk || !inKeep[3]) begin
                  dropCnt <= dropNext;
                  state   <= inLast ? IDLE : DROP;
               end else begin
                  hdrValid    <= 1'b1;
                  hdrSrcIp    <= srcIp;
                  hdrDstIp    <= {inData[7:0], inData[15:8], inData[23:16], inData[31:24]};
                  hdrProto    <= protocol;
                  hdrTotalLen <= totalLen;
                  residue     <= inData[127:32];
                  resCnt      <= hdr1Res;
                  remaining   <= totalLen - 16'd20;
                  // A header-only datagram still discards any trailing padding uncounted.
                  if (totalLen == 16'd20)  state <= inLast ? IDLE : DROP;
                  else if (inLast)         state <= (hdr1Res != 5'd0) ? FLUSH : IDLE;
                  else                     state <= PAYLOAD;
               end
            end
            PAYLOAD: if (beatAcc) begin
               outValid  <= 1'b1;
               outData   <= {inData[31:0], residue};
               outKeep   <= cntMask(emit);
               residue   <= inData[127:32];
               resCnt    <= newRes;
               remaining <= remAfter;
               if (remAfter == 16'd0) begin
                  outLast <= 1'b1;
                  state   <= inLast ? IDLE : DROP;
               end else if (inLast) begin
                  outLast <= (newRes == 5'd0);
                  state   <= (newRes == 5'd0) ? IDLE : FLUSH;
               end else begin
                  outLast <= 1'b0;
               end
            end
            FLUSH: if (outFree) begin
               outValid <= 1'b1;
               outData  <= {32'b0, residue};
               outKeep  <= cntMask(flushCnt);
               outLast  <= 1'b1;
               state    <= IDLE;
            end
            DROP: if (beatAcc && inLast) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.wMac_hdr_in_ready    = (state == IDLE) && rstDone;
   assign bus.wData_in_ready       = dataInReady;
   assign bus.wIp_hdr_out_valid    = hdrValid;
   assign bus.bIp_hdr_out_SrcIp    = hdrSrcIp;
   assign bus.bIp_hdr_out_DstIp    = hdrDstIp;
   assign bus.bIp_hdr_out_Protocol = hdrProto;
   assign bus.bIp_hdr_out_TotalLen = hdrTotalLen;
   assign bus.wData_out_valid      = outValid;
   assign bus.bData_out_data       = outData;
   assign bus.bData_out_keep       = outKeep;
   assign bus.wData_out_last       = outLast;
   assign bus.bDrop_cnt            = dropCnt;
endmodule

// File: tb/tb_ip_rx_process.sv
// tb/tb_ip_rx_process.sv - scoreboard bench for the IPv4 receive parser
// Stimulus pushes expected headers/beats; a negedge monitor pops and compares.
module tb_ip_rx_process;
   logic wClk   = 1'b0;
   logic wRst_n = 1'b1;
   always #5 wClk = ~wClk;

   ip_rx_process_if #(.DROP_CNT_W(16)) ifc ();
   ip_rx_process #(.DROP_CNT_W(16)) dut (.wClk(wClk), .wRst_n(wRst_n), .bus(ifc));

   typedef struct { logic [127:0] d; logic [15:0] k; logic l; } beat_t;
   typedef struct { logic [31:0] src; logic [31:0] dst; logic [7:0] proto; logic [15:0] len; } hdr_t;

   beat_t       expBeats[$];
   hdr_t        expHdrs[$];
   beat_t       eb;
   hdr_t        eh;
   logic [127:0] mask;
   int          nVec = 0;
   int          nFail = 0;
   int          beatsSeen = 0;
   logic [15:0] lastKeep = '0;
   logic [7:0]  frm [0:255];
   bit          randBp = 1'b0;
   bit          holdReady = 1'b1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(posedge wClk) begin
      #1;
      ifc.wData_out_ready   = randBp ? ($urandom_range(0, 1) == 1) : holdReady;
      ifc.bIp_hdr_out_ready = randBp ? ($urandom_range(0, 1) == 1) : holdReady;
   end

   always @(negedge wClk) begin
      if (wRst_n && ifc.wData_out_valid && ifc.wData_out_ready) begin
         beatsSeen++;
         lastKeep = ifc.bData_out_keep;
         if (expBeats.size() == 0) begin
            nVec++; nFail++;
            $display("FAIL unexpected_beat: got keep %0h, expected no beat", ifc.bData_out_keep);
         end else begin
            eb = expBeats.pop_front();
            for (int i = 0; i < 16; i++) mask[8*i +: 8] = {8{eb.k[i]}};
            check("out_keep", 128'(ifc.bData_out_keep), 128'(eb.k));
            check("out_last", 128'(ifc.wData_out_last), 128'(eb.l));
            check("out_data", ifc.bData_out_data & mask, eb.d & mask);
         end
      end
      if (wRst_n && ifc.wIp_hdr_out_valid && ifc.bIp_hdr_out_ready) begin
         if (expHdrs.size() == 0) begin
            nVec++; nFail++;
            $display("FAIL unexpected_hdr: got src %0h, expected no header", ifc.bIp_hdr_out_SrcIp);
         end else begin
            eh = expHdrs.pop_front();
            check("hdr_src",   128'(ifc.bIp_hdr_out_SrcIp),    128'(eh.src));
            check("hdr_dst",   128'(ifc.bIp_hdr_out_DstIp),    128'(eh.dst));
            check("hdr_proto", 128'(ifc.bIp_hdr_out_Protocol), 128'(eh.proto));
            check("hdr_len",   128'(ifc.bIp_hdr_out_TotalLen), 128'(eh.len));
         end
      end
   end

   function automatic logic [15:0] ipCsum();
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < 10; i++) if (i != 5) s = s + {16'b0, frm[2*i], frm[2*i+1]};
      while (s[31:16] != 16'd0) s = {16'b0, s[15:0]} + {16'b0, s[31:16]};
      return ~s[15:0];
   endfunction

   task automatic buildIp(input logic [7:0] b0, input logic [15:0] totLen, input logic [7:0] proto,
                          input logic [31:0] src, input logic [31:0] dst);
      logic [15:0] cs;
      for (int i = 0; i < 256; i++) frm[i] = 8'($urandom);
      frm[0] = b0;  frm[1] = 8'h00; frm[2] = totLen[15:8]; frm[3] = totLen[7:0];
      frm[4] = 8'h12; frm[5] = 8'h34; frm[6] = 8'h40; frm[7] = 8'h00;
      frm[8] = 8'h40; frm[9] = proto; frm[10] = 8'h00; frm[11] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         frm[12+i] = src[31-8*i -: 8];
         frm[16+i] = dst[31-8*i -: 8];
      end
      cs = ipCsum();
      frm[10] = cs[15:8];
      frm[11] = cs[7:0];
   endtask

   // Payload is IP bytes 20 .. min(TotalLen, frame)-1 in 16-byte chunks from lane 0.
   task automatic expectGood(input logic [15:0] totLen, input logic [7:0] proto,
                             input logic [31:0] src, input logic [31:0] dst, input int len);
      hdr_t h;
      beat_t b;
      int p;
      int n;
      h.src = src; h.dst = dst; h.proto = proto; h.len = totLen;
      expHdrs.push_back(h);
      p = ((int'(totLen) < len) ? int'(totLen) : len) - 20;
      for (int off = 0; off < p; off += 16) begin
         n = (p - off < 16) ? p - off : 16;
         b.d = '0;
         b.k = '0;
         for (int i = 0; i < n; i++) begin
            b.d[8*i +: 8] = frm[20+off+i];
            b.k[i] = 1'b1;
         end
         b.l = (off + 16 >= p);
         expBeats.push_back(b);
      end
   endtask

   task automatic waitReady(input bit isData, input string name);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge wClk);
         if (isData ? ifc.wData_in_ready : ifc.wMac_hdr_in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      nVec++;
      if (!ok) begin
         nFail++;
         $display("FAIL %s: got no ready in 300 cycles, expected handshake", name);
      end
      @(posedge wClk);
      #1;
   endtask

   task automatic sendFrame(input logic [15:0] ft, input int len, input int maxBeats);
      int nb;
      logic [127:0] d;
      logic [15:0] k;
      nb = (len + 15) / 16;
      ifc.wMac_hdr_in_valid     = 1'b1;
      ifc.bMac_hdr_in_FrameType = ft;
      waitReady(1'b0, "mac_hdr_timeout");
      ifc.wMac_hdr_in_valid = 1'b0;
      for (int b = 0; b < nb && b < maxBeats; b++) begin
         d = '0;
         k = '0;
         for (int i = 0; i < 16; i++) if (b*16 + i < len) begin
            d[8*i +: 8] = frm[b*16 + i];
            k[i] = 1'b1;
         end
         ifc.wData_in_valid = 1'b1;
         ifc.bData_in_data  = d;
         ifc.bData_in_keep  = k;
         ifc.wData_in_last  = (b == nb - 1);
         waitReady(1'b1, "data_in_timeout");
      end
      ifc.wData_in_valid = 1'b0;
      ifc.wData_in_last  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((expBeats.size() != 0 || expHdrs.size() != 0) && t < 2000) begin
         @(posedge wClk);
         t++;
      end
      check("drain_pending", 128'(expBeats.size() + expHdrs.size()), 128'(0));
      repeat (4) @(posedge wClk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_out_valid"}, 128'(ifc.wData_out_valid), 128'(0));
      check({tag, "_hdr_valid"}, 128'(ifc.wIp_hdr_out_valid), 128'(0));
      check({tag, "_in_ready"},  128'({ifc.wMac_hdr_in_ready, ifc.wData_in_ready}), 128'(0));
      check({tag, "_out_data"},  ifc.bData_out_data, 128'(0));
      check({tag, "_out_misc"},  128'({ifc.bData_out_keep, ifc.wData_out_last}), 128'(0));
      check({tag, "_hdr_flds"},  128'({ifc.bIp_hdr_out_SrcIp, ifc.bIp_hdr_out_DstIp,
                                       ifc.bIp_hdr_out_Protocol, ifc.bIp_hdr_out_TotalLen}), 128'(0));
      check({tag, "_drop_cnt"},  128'(ifc.bDrop_cnt), 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500us, expected completion");
      $fatal(1);
   end

   initial begin
      int b0;
      logic [15:0] tl;
      int ln;
      logic [31:0] sa, da;
      ifc.wMac_hdr_in_valid     = 1'b0;
      ifc.bMac_hdr_in_FrameType = '0;
      ifc.wData_in_valid        = 1'b0;
      ifc.bData_in_data         = '0;
      ifc.bData_in_keep         = '0;
      ifc.wData_in_last         = 1'b0;
      #1 wRst_n = 1'b0;
      repeat (3) @(posedge wClk);
      #1;
      checkAllZero("reset");
      wRst_n = 1'b1;
      @(posedge wClk);
      #1;
      check("idle_mac_ready", 128'(ifc.wMac_hdr_in_ready), 128'(1));
      check("idle_data_ready", 128'(ifc.wData_in_ready), 128'(0));

      // Good frame, TotalLen 64, 80 bytes: 44 payload bytes as FFFF, FFFF, 0FFF.
      buildIp(8'h45, 16'h0040, 8'h11, 32'hC0A80001, 32'hC0A80002);
      expectGood(16'h0040, 8'h11, 32'hC0A80001, 32'hC0A80002, 80);
      b0 = beatsSeen;
      sendFrame(16'h0800, 80, 99);
      drain();
      check("t1_beats", 128'(beatsSeen - b0), 128'(3));
      check("t1_last_keep", 128'(lastKeep), 128'(16'h0FFF));
      check("t1_drop", 128'(ifc.bDrop_cnt), 128'(0));

      // IPv6 EtherType: consumed and counted.
      buildIp(8'h45, 16'h0040, 8'h06, 32'h0A000001, 32'h0A000002);
      b0 = beatsSeen;
      sendFrame(16'h86DD, 64, 99);
      drain();
      check("t2_beats", 128'(beatsSeen - b0), 128'(0));
      check("t2_drop", 128'(ifc.bDrop_cnt), 128'(1));

      // Corrupted checksum byte, then a clean frame (flushed tail: 16, 16, 12).
      buildIp(8'h45, 16'h0040, 8'h06, 32'h0A000003, 32'h0A000004);
      frm[10] = frm[10] ^ 8'h01;
      sendFrame(16'h0800, 64, 99);
      drain();
      check("t3_drop", 128'(ifc.bDrop_cnt), 128'(2));
      buildIp(8'h45, 16'h0040, 8'h06, 32'h0A000005, 32'h0A000006);
      expectGood(16'h0040, 8'h06, 32'h0A000005, 32'h0A000006, 64);
      b0 = beatsSeen;
      sendFrame(16'h0800, 64, 99);
      drain();
      check("t3_beats", 128'(beatsSeen - b0), 128'(3));
      check("t3_last_keep", 128'(lastKeep), 128'(16'h0FFF));

      // TotalLen 46 in a 64-byte padded frame: FFFF then 03FF.
      buildIp(8'h45, 16'h002E, 8'h01, 32'h01020304, 32'h05060708);
      expectGood(16'h002E, 8'h01, 32'h01020304, 32'h05060708, 64);
      b0 = beatsSeen;
      sendFrame(16'h0800, 64, 99);
      drain();
      check("t4_beats", 128'(beatsSeen - b0), 128'(2));
      check("t4_last_keep", 128'(lastKeep), 128'(16'h03FF));
      check("t4_drop", 128'(ifc.bDrop_cnt), 128'(2));

      // Header-only datagram with padding.
      buildIp(8'h45, 16'd20, 8'h11, 32'hAABBCCDD, 32'h11223344);
      expectGood(16'd20, 8'h11, 32'hAABBCCDD, 32'h11223344, 48);
      b0 = beatsSeen;
      sendFrame(16'h0800, 48, 99);
      drain();
      check("t5_beats", 128'(beatsSeen - b0), 128'(0));
      check("t5_drop", 128'(ifc.bDrop_cnt), 128'(2));

      // Bad version/IHL byte, TotalLen below 20, header cut at 16 bytes.
      buildIp(8'h46, 16'h0040, 8'h11, 32'h1, 32'h2);
      sendFrame(16'h0800, 64, 99);
      buildIp(8'h45, 16'd19, 8'h11, 32'h3, 32'h4);
      sendFrame(16'h0800, 64, 99);
      buildIp(8'h45, 16'h0040, 8'h11, 32'h5, 32'h6);
      sendFrame(16'h0800, 16, 99);
      drain();
      check("t6_drop", 128'(ifc.bDrop_cnt), 128'(5));

      // Truncated: TotalLen 100 but only 52 bytes arrive; last lands on a full beat.
      buildIp(8'h45, 16'd100, 8'h06, 32'h7, 32'h8);
      expectGood(16'd100, 8'h06, 32'h7, 32'h8, 52);
      b0 = beatsSeen;
      sendFrame(16'h0800, 52, 99);
      drain();
      check("t7_beats", 128'(beatsSeen - b0), 128'(2));
      check("t7_last_keep", 128'(lastKeep), 128'(16'hFFFF));
      check("t7_drop", 128'(ifc.bDrop_cnt), 128'(5));

      // Backpressure on both outputs over 20 frames.
      randBp = 1'b1;
      for (int f = 0; f < 20; f++) begin
         tl = 16'($urandom_range(20, 100));
         ln = $urandom_range(20, 120);
         sa = $urandom;
         da = $urandom;
         buildIp(8'h45, tl, 8'(f), sa, da);
         expectGood(tl, 8'(f), sa, da, ln);
         sendFrame(16'h0800, ln, 99);
      end
      drain();
      randBp = 1'b0;
      holdReady = 1'b1;
      repeat (2) @(posedge wClk);
      #1;
      check("rand_drop", 128'(ifc.bDrop_cnt), 128'(5));

      // Reset while a payload beat and header are held pending.
      holdReady = 1'b0;
      repeat (2) @(posedge wClk);
      #1;
      buildIp(8'h45, 16'h0040, 8'h11, 32'h9, 32'hA);
      sendFrame(16'h0800, 80, 3);
      check("mid_out_valid", 128'(ifc.wData_out_valid), 128'(1));
      #2 wRst_n = 1'b0;
      #1;
      checkAllZero("midrst");
      repeat (2) @(posedge wClk);
      #1 wRst_n = 1'b1;
      holdReady = 1'b1;
      repeat (2) @(posedge wClk);
      #1;
      buildIp(8'h45, 16'h0040, 8'h11, 32'hB, 32'hC);
      expectGood(16'h0040, 8'h11, 32'hB, 32'hC, 80);
      b0 = beatsSeen;
      sendFrame(16'h0800, 80, 99);
      drain();
      check("post_rst_beats", 128'(beatsSeen - b0), 128'(3));
      check("post_rst_drop", 128'(ifc.bDrop_cnt), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end
endmodule
